erx_distributor: RTL



---
 rtl/erx_distributor_pkg.sv | 32 +++
 rtl/erx_skid_stage.sv | 56 +++++
 rtl/erx_distributor.sv | 74 +++++++
 3 files changed

// File: rtl/erx_distributor_pkg.sv
// Shared definitions for the receive distributor: emesh field offsets,
// channel indices and packet classification.
package erx_distributor_pkg;

  localparam int E_WRITE       = 0;
  localparam int E_DSTADDR_LSB = 8;
  localparam int E_DSTADDR_MSB = 39;

  localparam int CH_WR = 0;
  localparam int CH_RD = 1;
  localparam int CH_RR = 2;
  localparam int NCH   = 3;

  typedef enum logic [1:0] {
    CLS_WR = 2'd0,
    CLS_RD = 2'd1,
    CLS_RR = 2'd2
  } pkt_class_t;

  // Reads always go to RD; writes whose tag matches our ID are read responses.
  function automatic pkt_class_t classify(input logic        write,
                                          input logic [11:0] tag,
                                          input logic [11:0] id);
    if (!write)
      return CLS_RD;
    else if (tag == id)
      return CLS_RR;
    else
      return CLS_WR;
  endfunction

endpackage

// File: rtl/erx_skid_stage.sv
// One distributor channel: registered output plus a one-entry skid buffer
// that absorbs a packet accepted while the downstream FIFO is waiting.
module erx_skid_stage #(
  parameter int PW = 104
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load,
  input  logic [PW-1:0] packet_in,
  input  logic          fifo_wait,
  output logic          fifo_access,
  output logic [PW-1:0] fifo_packet,
  output logic          skid_valid_next
);

  logic          skid_valid;
  logic [PW-1:0] skid_packet;
  logic          drain;
  logic          out_free;
  logic          out_load_skid;
  logic          out_load_in;
  logic          skid_load;

  assign drain         = fifo_access & ~fifo_wait;
  assign out_free      = ~fifo_access | drain;
  // A waiting skid always goes first so packets leave in arrival order.
  assign out_load_skid = skid_valid & out_free;
  assign out_load_in   = ~skid_valid & load & out_free;
  assign skid_load     = load & (skid_valid | ~out_free);

  assign skid_valid_next = skid_load | (skid_valid & ~out_free);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fifo_access <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      if (out_load_skid || out_load_in)
        fifo_access <= 1'b1;
      else if (drain)
        fifo_access <= 1'b0;
    end
  end

  // Payload registers carry no reset; they are only meaningful while valid.
  always_ff @(posedge clk) begin
    if (out_load_skid)
      fifo_packet <= skid_packet;
    else if (out_load_in)
      fifo_packet <= packet_in;
    if (skid_load)
      skid_packet <= packet_in;
  end

endmodule

// File: rtl/erx_distributor.sv
// Receive-side router: classifies each emesh packet as write, read request
// or read response and steers it into one of three skid-buffered channels.
module erx_distributor
  import erx_distributor_pkg::*;
#(
  parameter int          PW = 104,
  parameter int          AW = 32,
  parameter logic [11:0] ID = 12'h810
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          access_in,
  input  logic [PW-1:0] packet_in,
  output logic          wait_out,
  output logic          rxwr_fifo_access,
  output logic [PW-1:0] rxwr_fifo_packet,
  input  logic          rxwr_fifo_wait,
  output logic          rxrd_fifo_access,
  output logic [PW-1:0] rxrd_fifo_packet,
  input  logic          rxrd_fifo_wait,
  output logic          rxrr_fifo_access,
  output logic [PW-1:0] rxrr_fifo_packet,
  input  logic          rxrr_fifo_wait
);

  pkt_class_t      pkt_class;
  logic            accept;
  logic [NCH-1:0]  load;
  logic [NCH-1:0]  fifo_wait;
  logic [NCH-1:0]  fifo_access;
  logic [NCH-1:0]  skid_valid_next;
  logic [PW-1:0]   fifo_packet [NCH];

  assign pkt_class = classify(packet_in[E_WRITE],
                              packet_in[E_DSTADDR_LSB+AW-1 -: 12], ID);
  assign accept    = access_in & ~wait_out;

  assign load[CH_WR] = accept & (pkt_class == CLS_WR);
  assign load[CH_RD] = accept & (pkt_class == CLS_RD);
  assign load[CH_RR] = accept & (pkt_class == CLS_RR);

  assign fifo_wait[CH_WR] = rxwr_fifo_wait;
  assign fifo_wait[CH_RD] = rxrd_fifo_wait;
  assign fifo_wait[CH_RR] = rxrr_fifo_wait;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    erx_skid_stage #(.PW(PW)) u_stage (
      .clk             (clk),
      .nreset          (nreset),
      .load            (load[ch]),
      .packet_in       (packet_in),
      .fifo_wait       (fifo_wait[ch]),
      .fifo_access     (fifo_access[ch]),
      .fifo_packet     (fifo_packet[ch]),
      .skid_valid_next (skid_valid_next[ch])
    );
  end

  assign rxwr_fifo_access = fifo_access[CH_WR];
  assign rxrd_fifo_access = fifo_access[CH_RD];
  assign rxrr_fifo_access = fifo_access[CH_RR];
  assign rxwr_fifo_packet = fifo_packet[CH_WR];
  assign rxrd_fifo_packet = fifo_packet[CH_RD];
  assign rxrr_fifo_packet = fifo_packet[CH_RR];

  // Stalling on any full skid guarantees no skid is ever asked to hold two.
  always_ff @(posedge clk) begin
    if (!nreset)
      wait_out <= 1'b0;
    else
      wait_out <= |skid_valid_next;
  end

endmodule
